// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory fill arbiter.
package mem_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Transfer owner encoding, also driven on fill_owner.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Block base of a 16-byte (8-word) cache block.
    localparam logic [15:0] BLOCK_MASK = 16'hFFF0;
    // Word alignment for single-word writes.
    localparam logic [15:0] WORD_MASK  = 16'hFFFE;

endpackage

// File: rtl/mem_arb_fill_seq.sv
// Issue/return word counters and issue address generation for one block fill.
// Counters clear whenever the arbiter is idle, so every grant starts at word 0.
module mem_arb_fill_seq #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        issue_en,
    input  logic        ret_en,
    input  logic [15:0] base,
    output logic [15:0] issue_addr,
    output logic        issue_last,
    output logic [2:0]  ret_idx,
    output logic        ret_last
);

    localparam int CW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_WORDS - 1);

    logic [CW-1:0] issue_cnt_q, issue_cnt_d;
    logic [CW-1:0] ret_cnt_q, ret_cnt_d;

    // Next counter values: clear while idle, otherwise step on each issue/return.
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        if (clear) begin
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
        end else begin
            if (issue_en) issue_cnt_d = issue_cnt_q + CW'(1);
            if (ret_en)   ret_cnt_d   = ret_cnt_q + CW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    // Word addresses advance by 2 bytes from the block base.
    always_comb begin
        issue_addr = base + (16'(issue_cnt_q) << 1);
        issue_last = (issue_cnt_q == LAST_WORD);
        ret_idx    = 3'(ret_cnt_q);
        ret_last   = ret_en && (ret_cnt_q == LAST_WORD);
    end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the unified 16-bit memory port between I-side fills and D-side
// fills/writes. D normally wins, but after STARVE_MAX consecutive D grants
// with I waiting, I is forced through.
// Optional build macro MEM_ARB_PERF_EN adds saturating performance counters.
//
// Handshake: a requester raises *_req and holds it (with stable address/data
// until the grant) until its one-cycle *_done pulse; its inputs are latched at
// the grant and ignored afterwards. fill_valid qualifies fill_owner, fill_idx
// and fill_data in the same cycle and has no back-pressure.
module mem_fill_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LATENCY = 4,
    parameter int STARVE_MAX  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        fill_valid,
    output logic        fill_owner,
    output logic [2:0]  fill_idx,
    output logic [15:0] fill_data,
    output logic        i_done,
    output logic        d_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0] perf_conflicts,
    output logic [15:0] perf_i_wait,
    output logic [15:0] perf_fills
`endif
);

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic [15:0]    addr_q, addr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic [SW-1:0]  starve_q, starve_d;

    logic           d_win;
    logic           issue_en;
    logic           ret_en;
    logic [15:0]    issue_addr;
    logic           issue_last;
    logic [2:0]     ret_idx;
    logic           ret_last;

    mem_arb_fill_seq #(
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_fill_seq (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_q == ST_IDLE),
        .issue_en   (issue_en),
        .ret_en     (ret_en),
        .base       (addr_q),
        .issue_addr (issue_addr),
        .issue_last (issue_last),
        .ret_idx    (ret_idx),
        .ret_last   (ret_last)
    );

    // Returns are only accepted while a fill is in flight; strays in IDLE drop.
    assign ret_en = mem_rvalid && ((state_q == ST_FILL) || (state_q == ST_DRAIN));

    // Next-state, grant latching and memory-port drive.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        starve_d  = starve_q;
        d_win     = 1'b0;
        issue_en  = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        i_done    = 1'b0;
        d_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                d_win = d_req && (!i_req || (starve_q < STARVE_LIM));
                if (d_win) begin
                    owner_d = OWN_D;
                    addr_d  = d_wr ? (d_addr & WORD_MASK) : (d_addr & BLOCK_MASK);
                    wdata_d = d_wdata;
                    if (i_req) starve_d = starve_q + SW'(1);
                    state_d = d_wr ? ST_WRITE : ST_FILL;
                end else if (i_req) begin
                    owner_d  = OWN_I;
                    addr_d   = i_addr & BLOCK_MASK;
                    starve_d = '0;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                issue_en = 1'b1;
                mem_en   = 1'b1;
                mem_addr = issue_addr;
                if (ret_last)        state_d = ST_DONE;
                else if (issue_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (ret_last) state_d = ST_DONE;
            end
            ST_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                i_done  = (owner_q == OWN_I);
                d_done  = (owner_q == OWN_D);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Fill return path, zero whenever no return is accepted.
    always_comb begin
        fill_valid = ret_en;
        fill_owner = 1'b0;
        fill_idx   = 3'd0;
        fill_data  = 16'h0000;
        if (ret_en) begin
            fill_owner = owner_q;
            fill_idx   = ret_idx;
            fill_data  = mem_rdata;
        end
        busy = (state_q != ST_IDLE);
    end

    // State and latched-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_I;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [15:0] perf_conflicts_q, perf_conflicts_d;
    logic [15:0] perf_i_wait_q, perf_i_wait_d;
    logic [15:0] perf_fills_q, perf_fills_d;

    // Saturating event counters.
    always_comb begin
        perf_conflicts_d = perf_conflicts_q;
        perf_i_wait_d    = perf_i_wait_q;
        perf_fills_d     = perf_fills_q;
        if ((state_q == ST_IDLE) && i_req && d_req && (perf_conflicts_q != 16'hFFFF))
            perf_conflicts_d = perf_conflicts_q + 16'd1;
        if (i_req && !((state_q != ST_IDLE) && (owner_q == OWN_I)) && (perf_i_wait_q != 16'hFFFF))
            perf_i_wait_d = perf_i_wait_q + 16'd1;
        if (ret_last && (perf_fills_q != 16'hFFFF))
            perf_fills_d = perf_fills_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflicts_q <= 16'h0000;
            perf_i_wait_q    <= 16'h0000;
            perf_fills_q     <= 16'h0000;
        end else begin
            perf_conflicts_q <= perf_conflicts_d;
            perf_i_wait_q    <= perf_i_wait_d;
            perf_fills_q     <= perf_fills_d;
        end
    end

    assign perf_conflicts = perf_conflicts_q;
    assign perf_i_wait    = perf_i_wait_q;
    assign perf_fills     = perf_fills_q;
`endif

    // Every read issue must be answered exactly MEM_LATENCY cycles later.
    a_rvalid_latency: assert property (@(posedge clk) disable iff (rst)
        (mem_en && !mem_wr) |-> ##MEM_LATENCY mem_rvalid);

    // The memory port is only driven from FILL or WRITE.
    a_mem_en_state: assert property (@(posedge clk)
        !(mem_en && ((state_q == ST_IDLE) || (state_q == ST_DRAIN) || (state_q == ST_DONE))));

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Shares the single 16-bit, word-granular unified memory port between the I-cache miss handler and the D-cache miss/write-through path.
- Sequences 8-word block fills (16 bytes) as back-to-back pipelined word reads, and sequences single-word D-side writes.
- Returns fill words to the owning requester.
- Sits between the two cache controllers and the multi-cycle memory, which asserts mem_rvalid a fixed number of cycles after each read issue.

Parameters:
- BLOCK_WORDS, 8, words per cache block; must be a power of 2.
- MEM_LATENCY, 4, cycles from read issue to mem_rvalid. Used only by assertions and the bench; the arbiter itself counts returns.
- STARVE_MAX, 2, consecutive D grants allowed while I waits before I is forced.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- i_req, input, 1, I-side fill request; held until i_done.
- i_addr, input, 16, I-side miss byte address.
- d_req, input, 1, D-side request; held until d_done.
- d_wr, input, 1, D-side request is a single-word write (1) or a fill (0).
- d_addr, input, 16, D-side byte address.
- d_wdata, input, 16, D-side write data.
- fill_valid, output, 1, fill_data is valid this cycle.
- fill_owner, output, 1, 0 = I-side, 1 = D-side.
- fill_idx, output, 3, word index within the block.
- fill_data, output, 16, returned word.
- i_done, output, 1, one-cycle pulse: I fill complete.
- d_done, output, 1, one-cycle pulse: D fill or write complete.
- mem_en, output, 1, memory access enable.
- mem_wr, output, 1, memory write.
- mem_addr, output, 16, memory byte address; bit 0 is always 0.
- mem_wdata, output, 16, memory write data.
- mem_rdata, input, 16, memory read data.
- mem_rvalid, input, 1, mem_rdata valid.
- busy, output, 1, state is not IDLE.

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock. On reset:
  - state goes to IDLE; issue/return counters and starve counter clear.
  - All outputs are 0.
  - Reset mid-fill abandons the transfer with no done pulse. Any mem_rvalid seen in IDLE is ignored.
- States: IDLE, FILL, DRAIN, WRITE, DONE.
- IDLE arbitration, evaluated each cycle:
  - D wins if d_req and either !i_req or starve_cnt < STARVE_MAX.
  - Otherwise I wins if i_req.
  - A D grant while i_req is high increments starve_cnt. An I grant clears it.
  - On grant, the owner, block base (addr & 16'hFFF0) and wdata are latched. Requester inputs are ignored after the latch.
  - Next state is WRITE for a D write, else FILL.
- FILL:
  - Drives mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt, one word per cycle.
  - issue_cnt increments each cycle. After issue of word BLOCK_WORDS-1, go to DRAIN.
  - Exactly 8 consecutive issue cycles.
- Returns (in FILL and DRAIN):
  - Each mem_rvalid drives fill_valid=1, fill_data=mem_rdata, fill_idx=ret_cnt and fill_owner combinationally in the same cycle; ret_cnt then increments.
  - When ret_cnt reaches BLOCK_WORDS, go to DONE.
- WRITE: one cycle with mem_en=1, mem_wr=1, mem_addr=latched d_addr with bit 0 forced to 0, mem_wdata=latched data. Then go to DONE.
- DONE: one cycle. Pulse i_done or d_done for the owner, then return to IDLE. A new grant is possible the next cycle.
- Latency:
  - I fill with no contention: i_req at cycle 0, first issue at cycle 1, last return at cycle 8+MEM_LATENCY, i_done one cycle later.
  - D write: d_done 2 cycles after grant.
- mem_en is never high in IDLE, DRAIN or DONE.
- Read and write are never concurrent.
- fill_idx wraps naturally at 3 bits.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds 16-bit saturating counters with output ports perf_conflicts (cycles in IDLE with both req high), perf_i_wait (cycles with i_req high and not owner), and perf_fills (completed fills). All clear on rst.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum (IDLE, FILL, DRAIN, WRITE, DONE);
  - owner constants OWN_I=0 and OWN_D=1;
  - BLOCK_MASK 16'hFFF0.
- One natural sub-module: mem_arb_fill_seq (issue/return counters and address generation), instantiated once.

Test Plan:
- I fill alone: i_req, i_addr=16'h0126 → mem_addr 0x0120,0x0122,…,0x012E on 8 consecutive cycles; fill_idx 0..7 with owner 0; i_done at cycle 13 (MEM_LATENCY=4).
- D write: d_req, d_wr, d_addr=16'h4003, d_wdata=16'hBEEF → one cycle mem_en=1, mem_wr=1, mem_addr=0x4002, mem_wdata=0xBEEF; d_done next cycle.
- Simultaneous: i_req and d_req (fill) both held from cycle 0 → grant order D, D, I under continued D requests (STARVE_MAX=2); fill_owner tracks the grants.
- Reset mid-fill: rst asserted after 3 issues → next cycle busy=0 and all outputs 0; no done pulse; stray mem_rvalid ignored; a subsequent fill completes normally.
- Back-to-back: i_req re-asserted in the cycle after i_done → new FILL starts with no idle gap beyond one IDLE cycle; fill_idx restarts at 0.
- MEM_ARB_PERF_EN: the conflict scenario yields a nonzero perf_conflicts count and perf_fills=3.
